wordreader: RTL and testbench

Serial receive path for the word board: the inverse of the `cereal` transmitter. It deserialises an 8N1 asynchronous line (idle high, LSB first) into bytes and assembles them into a word buffer terminated by carriage return (0x0D). It then presents the completed word, with its length, to downstream logic through a random-access read port and a ready/ack handshake. It sits between the board's RX pin and any consumer that echoes or compares received words.

---
 rtl/wordreader_pkg.sv | 27 ++
 rtl/wordreader_cereal_rx.sv | 184 ++++++++++++++++++
 rtl/wordreader.sv | 137 +++++++++++++
 tb/tb_wordreader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wordreader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wordreader_pkg
//  Description : Shared types and constants for the wordreader receive path:
//                RX state encodings, carriage-return terminator and the
//                character-count width.
//  Revision    : 1.0 - initial release
// ============================================================================
package wordreader_pkg;

    // Receive FSM states
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Word terminator
    localparam logic [7:0] CHAR_CR = 8'h0D;

    // Width of the character count, word length and read address
    localparam int COUNT_W = 6;

endpackage : wordreader_pkg
`default_nettype wire

// File: rtl/wordreader_cereal_rx.sv
`default_nettype none
// ============================================================================
//  Module      : cereal_rx
//  Description : 8N1 asynchronous receiver. Two-flop synchroniser, half-bit
//                start qualification, mid-bit sampling of eight LSB-first data
//                bits and a stop-bit check. Emits one-cycle char_valid or
//                frame_err pulses; a low stop bit parks the FSM in BREAK until
//                the line idles high again.
//  Revision    : 1.0 - initial release
// ============================================================================
module cereal_rx
    import wordreader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rx,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic       frame_err
);

    localparam int               c_BCW     = $clog2(CLKS_PER_BIT);
    localparam logic [c_BCW-1:0] c_HALF_M1 = c_BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_BCW-1:0] c_FULL_M1 = c_BCW'(CLKS_PER_BIT - 1);
    localparam logic [c_BCW-1:0] c_ONE     = c_BCW'(1);

    // Synchroniser and edge detector
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync_d;
    logic [1:0]       r_warm;
    logic             r_armed;

    // FSM and datapath state
    rx_state_t        r_state;
    logic [c_BCW-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_char_valid;
    logic [7:0]       r_char_data;
    logic             r_frame_err;

    // Next-state values
    rx_state_t        w_state_next;
    logic [c_BCW-1:0] w_bit_cnt_next;
    logic [2:0]       w_bit_idx_next;
    logic [7:0]       w_shift_next;
    logic             w_char_valid_next;
    logic [7:0]       w_char_data_next;
    logic             w_frame_err_next;

    logic             w_start;
    logic             w_tick;

    // A start needs a genuine high-to-low transition. The synchroniser resets
    // to 1, so edges are only trusted once a real high has been observed after
    // the synchroniser has flushed its reset value (r_armed). This keeps a line
    // held low through reset release from looking like a start bit.
    assign w_start = r_armed & r_sync_d & ~r_sync2;
    assign w_tick  = (r_bit_cnt == '0);

    // Synchronise rx into sysclk and track when the edge detector can be trusted
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
            r_warm   <= 2'b00;
            r_armed  <= 1'b0;
        end else begin
            r_sync1  <= rx;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            r_warm   <= {r_warm[0], 1'b1};
            if (r_warm[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state      <= RX_IDLE;
            r_bit_cnt    <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_char_valid <= 1'b0;
            r_char_data  <= 8'h00;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_bit_idx    <= w_bit_idx_next;
            r_shift      <= w_shift_next;
            r_char_valid <= w_char_valid_next;
            r_char_data  <= w_char_data_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    // Next-state and output decode; counters hold and pulses drop by default
    always_comb begin
        w_state_next      = r_state;
        w_bit_cnt_next    = r_bit_cnt;
        w_bit_idx_next    = r_bit_idx;
        w_shift_next      = r_shift;
        w_char_valid_next = 1'b0;
        w_char_data_next  = r_char_data;
        w_frame_err_next  = 1'b0;

        case (r_state)
            RX_IDLE: begin
                if (w_start) begin
                    w_bit_cnt_next = c_HALF_M1;
                    w_state_next   = RX_START;
                end
            end

            RX_START: begin
                if (w_tick) begin
                    if (!r_sync2) begin
                        w_bit_cnt_next = c_FULL_M1;
                        w_bit_idx_next = 3'd0;
                        w_state_next   = RX_DATA;
                    end else begin
                        // Line bounced back high before mid-start: a glitch
                        w_state_next = RX_IDLE;
                    end
                end else begin
                    w_bit_cnt_next = r_bit_cnt - c_ONE;
                end
            end

            RX_DATA: begin
                if (w_tick) begin
                    w_shift_next   = {r_sync2, r_shift[7:1]};
                    w_bit_cnt_next = c_FULL_M1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = RX_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_bit_cnt_next = r_bit_cnt - c_ONE;
                end
            end

            RX_STOP: begin
                if (w_tick) begin
                    if (r_sync2) begin
                        // Return to IDLE mid-stop so a following start edge is seen
                        w_char_valid_next = 1'b1;
                        w_char_data_next  = r_shift;
                        w_state_next      = RX_IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = RX_BREAK;
                    end
                end else begin
                    w_bit_cnt_next = r_bit_cnt - c_ONE;
                end
            end

            RX_BREAK: begin
                if (r_sync2) begin
                    w_state_next = RX_IDLE;
                end
            end

            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

    assign char_valid = r_char_valid;
    assign char_data  = r_char_data;
    assign frame_err  = r_frame_err;

endmodule : cereal_rx
`default_nettype wire

// File: rtl/wordreader.sv
`default_nettype none
// ============================================================================
//  Module      : wordreader
//  Description : Serial word receiver. Deserialises 8N1 bytes via cereal_rx,
//                collects them into a buffer until a carriage return, then
//                holds the word with its length for a consumer that reads it
//                through a registered random-access port and releases it
//                with ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module wordreader
    import wordreader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int MAX_CHARS    = 32
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               rx,
    output logic               char_valid,
    output logic [7:0]         char_data,
    output logic               frame_err,
    output logic               word_ready,
    output logic [COUNT_W-1:0] word_len,
    output logic               overflow,
    input  logic               ack,
    input  logic [COUNT_W-1:0] rd_addr,
    output logic [7:0]         rd_data
);

    localparam int                 c_AW  = $clog2(MAX_CHARS);
    localparam logic [COUNT_W-1:0] c_MAX = COUNT_W'(MAX_CHARS);
    localparam logic [COUNT_W-1:0] c_ONE = COUNT_W'(1);

    logic               w_char_valid;
    logic [7:0]         w_char_data;
    logic               w_frame_err;

    logic [7:0]         r_buf [MAX_CHARS];
    logic [COUNT_W-1:0] r_count;
    logic               r_word_ready;
    logic [COUNT_W-1:0] r_word_len;
    logic               r_overflow;
    logic [7:0]         r_rd_data;

    logic               w_ready_eff;
    logic               w_wr_en;
    logic               w_accept_cr;
    logic               w_drop;

    cereal_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .sysclk     (sysclk),
        .reset      (reset),
        .rx         (rx),
        .char_valid (w_char_valid),
        .char_data  (w_char_data),
        .frame_err  (w_frame_err)
    );

    // An ack in the same cycle releases the buffer before the character lands
    assign w_ready_eff = r_word_ready & ~ack;

    // Decide what the incoming character does to the word buffer
    always_comb begin
        w_wr_en     = 1'b0;
        w_accept_cr = 1'b0;
        w_drop      = 1'b0;
        if (w_char_valid) begin
            if (w_ready_eff) begin
                w_drop = 1'b1;
            end else if (w_char_data == CHAR_CR) begin
                // A bare terminator with nothing collected is an empty line
                w_accept_cr = (r_count != '0);
            end else if (r_count < c_MAX) begin
                w_wr_en = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    // Character count, word handshake and sticky overflow
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_word_ready <= 1'b0;
            r_word_len   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (ack) begin
                r_word_ready <= 1'b0;
                r_overflow   <= 1'b0;
            end
            if (w_accept_cr) begin
                r_word_ready <= 1'b1;
                r_word_len   <= r_count;
                r_count      <= '0;
            end
            if (w_wr_en) begin
                r_count <= r_count + c_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Buffer storage; contents are undefined until written
    always_ff @(posedge sysclk) begin
        if (w_wr_en) begin
            r_buf[r_count[c_AW-1:0]] <= w_char_data;
        end
    end

    // Registered read port; addresses past the buffer read as zero
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rd_data <= 8'h00;
        end else if (rd_addr >= c_MAX) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= r_buf[rd_addr[c_AW-1:0]];
        end
    end

    assign char_valid = w_char_valid;
    assign char_data  = w_char_data;
    assign frame_err  = w_frame_err;
    assign word_ready = r_word_ready;
    assign word_len   = r_word_len;
    assign overflow   = r_overflow;
    assign rd_data    = r_rd_data;

endmodule : wordreader
`default_nettype wire

// File: tb/tb_wordreader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wordreader
//  Description : Directed self-checking bench for wordreader with a short
//                bit period. Drives 8N1 frames on rx and compares outputs
//                against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wordreader;

    localparam int CPB  = 16;
    localparam int MAXC = 32;

    logic       sysclk;
    logic       reset;
    logic       rx;
    logic       char_valid;
    logic [7:0] char_data;
    logic       frame_err;
    logic       word_ready;
    logic [5:0] word_len;
    logic       overflow;
    logic       ack;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Event counters maintained by the monitor; tests compare deltas
    int         cv_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] last_data = 8'h00;
    int         cv_base;
    int         fe_base;

    wordreader #(
        .CLKS_PER_BIT (CPB),
        .MAX_CHARS    (MAXC)
    ) u_dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .rx         (rx),
        .char_valid (char_valid),
        .char_data  (char_data),
        .frame_err  (frame_err),
        .word_ready (word_ready),
        .word_len   (word_len),
        .overflow   (overflow),
        .ack        (ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Count output pulses away from the active edge
    always @(negedge sysclk) begin
        if (char_valid) begin
            cv_cnt    <= cv_cnt + 1;
            last_data <= char_data;
        end
        if (frame_err) begin
            fe_cnt <= fe_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge sysclk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge sysclk);
    endtask

    task automatic mark();
        @(negedge sysclk);
        cv_base = cv_cnt;
        fe_base = fe_cnt;
    endtask

    task automatic read_chk(input string tag, input logic [5:0] addr, input logic [7:0] exp);
        @(negedge sysclk);
        rd_addr = addr;
        @(negedge sysclk);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic pulse_ack();
        @(negedge sysclk);
        ack = 1'b1;
        @(negedge sysclk);
        ack = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic do_reset();
        rx = 1'b1;
        @(negedge sysclk);
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        ack     = 1'b0;
        rd_addr = 6'd0;
        repeat (3) @(negedge sysclk);

        // Reset state
        check("rst_char_valid", {31'd0, char_valid}, 32'd0);
        check("rst_char_data",  {24'd0, char_data},  32'd0);
        check("rst_frame_err",  {31'd0, frame_err},  32'd0);
        check("rst_word_ready", {31'd0, word_ready}, 32'd0);
        check("rst_word_len",   {26'd0, word_len},   32'd0);
        check("rst_overflow",   {31'd0, overflow},   32'd0);
        check("rst_rd_data",    {24'd0, rd_data},    32'd0);
        reset = 1'b0;
        idle(8);

        // Single byte
        mark();
        send_byte(8'h41);
        idle(4);
        check("single_cv_count", cv_cnt - cv_base, 1);
        check("single_data", {24'd0, last_data}, 32'h41);
        check("single_fe_count", fe_cnt - fe_base, 0);
        check("single_word_ready", {31'd0, word_ready}, 32'd0);

        // Word read-back
        do_reset();
        send_byte(8'h48);
        send_byte(8'h49);
        send_byte(8'h0D);
        idle(4);
        check("hi_word_ready", {31'd0, word_ready}, 32'd1);
        check("hi_word_len", {26'd0, word_len}, 32'd2);
        read_chk("hi_rd0", 6'd0, 8'h48);
        read_chk("hi_rd1", 6'd1, 8'h49);
        read_chk("hi_rd40", 6'd40, 8'h00);
        pulse_ack();
        check("hi_ack_ready", {31'd0, word_ready}, 32'd0);

        // Framing error, then a good byte
        mark();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h55 >> i) & 8'h01) != 8'h00);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge sysclk);
        idle(2 * CPB);
        check("fe_count", fe_cnt - fe_base, 1);
        check("fe_no_cv", cv_cnt - cv_base, 0);
        mark();
        send_byte(8'h31);
        idle(4);
        check("after_fe_cv", cv_cnt - cv_base, 1);
        check("after_fe_data", {24'd0, last_data}, 32'h31);

        // Short glitch on the line
        mark();
        rx = 1'b0;
        repeat (4) @(negedge sysclk);
        idle(3 * CPB);
        check("glitch_cv", cv_cnt - cv_base, 0);
        check("glitch_fe", fe_cnt - fe_base, 0);
        mark();
        send_byte(8'h7E);
        idle(4);
        check("post_glitch_cv", cv_cnt - cv_base, 1);
        check("post_glitch_data", {24'd0, last_data}, 32'h7E);

        // Overflow: 33 characters into a 32-deep buffer
        do_reset();
        for (int i = 0; i < 33; i++) send_byte(8'h61);
        send_byte(8'h0D);
        idle(4);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_word_ready", {31'd0, word_ready}, 32'd1);
        check("ovf_word_len", {26'd0, word_len}, 32'd32);
        read_chk("ovf_rd31", 6'd31, 8'h61);
        send_byte(8'h62);
        idle(4);
        check("ovf_drop_len", {26'd0, word_len}, 32'd32);
        read_chk("ovf_drop_rd0", 6'd0, 8'h61);
        pulse_ack();
        check("ovf_ack_flag", {31'd0, overflow}, 32'd0);
        check("ovf_ack_ready", {31'd0, word_ready}, 32'd0);

        // Empty line, then back-to-back frames
        send_byte(8'h0D);
        idle(4);
        check("empty_line_ready", {31'd0, word_ready}, 32'd0);
        mark();
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h0D);
        idle(4);
        check("b2b_cv", cv_cnt - cv_base, 3);
        check("b2b_ready", {31'd0, word_ready}, 32'd1);
        check("b2b_len", {26'd0, word_len}, 32'd2);
        read_chk("b2b_rd0", 6'd0, 8'h41);
        read_chk("b2b_rd1", 6'd1, 8'h42);

        // Reset in the middle of a frame, line held low through release
        rd_addr = 6'd0;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b0;
        repeat (5) @(negedge sysclk);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        check("midrst_word_ready", {31'd0, word_ready}, 32'd0);
        check("midrst_word_len",   {26'd0, word_len},   32'd0);
        check("midrst_char_data",  {24'd0, char_data},  32'd0);
        check("midrst_overflow",   {31'd0, overflow},   32'd0);
        @(negedge sysclk);
        mark();
        reset = 1'b0;
        repeat (12 * CPB) @(negedge sysclk);
        check("low_release_cv", cv_cnt - cv_base, 0);
        check("low_release_fe", fe_cnt - fe_base, 0);
        idle(2 * CPB);
        mark();
        send_byte(8'h5A);
        idle(4);
        check("resume_cv", cv_cnt - cv_base, 1);
        check("resume_data", {24'd0, last_data}, 32'h5A);
        check("resume_char_data", {24'd0, char_data}, 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wordreader
`default_nettype wire
